countdown_timer: RTL and testbench

- Loadable down-counting game timer for the frog's per-life time limit.
- A prescaler divides clk into decrement ticks; the count runs down to zero and then raises an expiry event for the game-control FSM.
- Supports pause (hold), saturating bonus-time add, and two BCD digits for the score/time display.
- It is the consuming, down-counting counterpart of the free-running up-counters in the design.

---
 rtl/frogger_timer_pkg.sv | 15 +
 rtl/bcd_split.sv | 15 +
 rtl/countdown_timer.sv | 132 +++++++++++++
 tb/tb_countdown_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_timer_pkg.sv
// Shared timer definitions: FSM state encoding and default timing constants
// used by the frog's per-life countdown timer.
package frogger_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  localparam int unsigned TIMER_START = 60;
  localparam int unsigned TIMER_MAX   = 99;

endpackage : frogger_timer_pkg

// File: rtl/bcd_split.sv
// Combinational binary (0..99) to two-digit BCD converter; shared with the
// score display path.
module bcd_split #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones
);

  // Inputs are bounded to 0..99, so both digits fit in 4 bits.
  assign o_tens = 4'(i_bin / WIDTH'(10));
  assign o_ones = 4'(i_bin % WIDTH'(10));

endmodule : bcd_split

// File: rtl/countdown_timer.sv
// Loadable down-counting game timer with prescaler, pause, saturating bonus
// add, one-shot expiry event and BCD digit outputs.
module countdown_timer
  import frogger_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned START_VALUE = TIMER_START,
  parameter int unsigned MAX_VALUE   = TIMER_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_val,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             expire_pulse,
  output logic             tick,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_START = WIDTH'(START_VALUE);
  localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MAX_VALUE);

  timer_state_e     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [PW-1:0]    r_prescale, w_prescale_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_expire_pulse, w_expire_pulse_nxt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_added;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_dec;
  logic             w_wrap;

  // Bonus is saturated before any same-edge decrement, so a bonus landing on
  // the wrap edge can rescue a count of 1 from expiring.
  assign w_sum   = {1'b0, r_count} + {1'b0, add_val};
  assign w_added = (w_sum > {1'b0, CNT_MAX}) ? CNT_MAX : w_sum[WIDTH-1:0];
  assign w_base  = add_en ? w_added : r_count;
  assign w_dec   = w_base - WIDTH'(1);
  assign w_wrap  = (r_prescale == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_count        <= CNT_START;
      r_prescale     <= '0;
      r_tick         <= 1'b0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_prescale     <= w_prescale_nxt;
      r_tick         <= w_tick_nxt;
      r_expire_pulse <= w_expire_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_count_nxt        = r_count;
    w_prescale_nxt     = r_prescale;
    w_tick_nxt         = 1'b0;
    w_expire_pulse_nxt = 1'b0;

    if (start) begin
      w_state_nxt    = ST_RUN;
      w_count_nxt    = CNT_START;
      w_prescale_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_RUN: begin
          if (hold) begin
            w_state_nxt = ST_PAUSE;
            w_count_nxt = w_base;
          end else if (w_wrap) begin
            w_prescale_nxt = '0;
            w_tick_nxt     = 1'b1;
            if (w_dec == '0) begin
              w_state_nxt        = ST_EXPIRED;
              w_count_nxt        = '0;
              w_expire_pulse_nxt = 1'b1;
            end else begin
              w_count_nxt = w_dec;
            end
          end else begin
            w_prescale_nxt = r_prescale + PW'(1);
            w_count_nxt    = w_base;
          end
        end
        ST_PAUSE: begin
          w_count_nxt = w_base;
          if (!hold) w_state_nxt = ST_RUN;
        end
        ST_EXPIRED: begin
          w_count_nxt    = '0;
          w_prescale_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign count        = r_count;
  assign running      = (r_state == ST_RUN);
  assign paused       = (r_state == ST_PAUSE);
  assign expired      = (r_state == ST_EXPIRED);
  assign expire_pulse = r_expire_pulse;
  assign tick         = r_tick;

  bcd_split #(
    .WIDTH(WIDTH)
  ) u_bcd_split (
    .i_bin  (r_count),
    .o_tens (bcd_tens),
    .o_ones (bcd_ones)
  );

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// stimulus, each cycle compared against a behavioural timer model.
module tb_countdown_timer;

  localparam int unsigned W     = 8;
  localparam int unsigned TDIV  = 4;
  localparam int unsigned START = 60;
  localparam int unsigned MAXV  = 99;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic         add_en = 1'b0;
  logic [W-1:0] add_val = '0;
  logic [W-1:0] count;
  logic         running, paused, expired, expire_pulse, tick;
  logic [3:0]   bcd_tens, bcd_ones;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the timer
  int m_count = START;
  int m_pre   = 0;
  bit m_run   = 1'b0;
  bit m_pause = 1'b0;
  bit m_exp   = 1'b0;
  bit m_tick  = 1'b0;
  bit m_ep    = 1'b0;

  countdown_timer #(
    .WIDTH       (W),
    .TICK_DIV    (TDIV),
    .START_VALUE (START),
    .MAX_VALUE   (MAXV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hold         (hold),
    .add_en       (add_en),
    .add_val      (add_val),
    .count        (count),
    .running      (running),
    .paused       (paused),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .tick         (tick),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit hd, input bit ae, input int av);
    int base;
    m_tick = 1'b0;
    m_ep   = 1'b0;
    if (rst) begin
      m_run = 0; m_pause = 0; m_exp = 0; m_count = START; m_pre = 0;
    end else if (st) begin
      m_run = 1; m_pause = 0; m_exp = 0; m_count = START; m_pre = 0;
    end else if (m_exp) begin
      m_count = 0; m_pre = 0;
    end else if (m_run || m_pause) begin
      base = m_count;
      if (ae) base = (m_count + av > MAXV) ? MAXV : m_count + av;
      if (m_run && hd) begin
        m_run = 0; m_pause = 1;
      end else if (m_pause) begin
        if (!hd) begin m_pause = 0; m_run = 1; end
      end else if (m_pre == TDIV - 1) begin
        m_pre  = 0;
        base   = base - 1;
        m_tick = 1;
        if (base == 0) begin
          m_run = 0; m_exp = 1; m_ep = 1;
        end
      end else begin
        m_pre++;
      end
      m_count = base;
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit hd, input bit ae, input int av);
    reset   = rst;
    start   = st;
    hold    = hd;
    add_en  = ae;
    add_val = W'(av);
    @(posedge clk);
    model_edge(rst, st, hd, ae, av);
    #1;
    check("count",        count,        m_count);
    check("running",      running,      m_run);
    check("paused",       paused,       m_pause);
    check("expired",      expired,      m_exp);
    check("expire_pulse", expire_pulse, m_ep);
    check("tick",         tick,         m_tick);
    check("bcd_tens",     bcd_tens,     m_count / 10);
    check("bcd_ones",     bcd_ones,     m_count % 10);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    bit r_hold;
    #2;
    repeat (3) step(1, 0, 0, 0, 0);
    check("rst_count", count, 60);
    check("rst_flags", {running, paused, expired, expire_pulse, tick}, 0);

    // First decrement lands TICK_DIV cycles after start
    step(0, 1, 0, 0, 0);
    check("start_running", running, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("pre_first_tick", count, 60);
    end
    idle(1);
    check("first_dec", count, 59);
    check("first_tick", tick, 1);
    check("first_tens", bcd_tens, 5);
    check("first_ones", bcd_ones, 9);
    idle(1);
    check("tick_one_cycle", tick, 0);

    // Run to zero: 59 at prescale 1 -> 0 after 235 more cycles
    idle(235);
    check("zero_count", count, 0);
    check("zero_pulse", expire_pulse, 1);
    check("zero_expired", expired, 1);
    idle(1);
    check("pulse_once", expire_pulse, 0);
    idle(100);
    check("exp_hold", count, 0);
    step(0, 0, 0, 1, 10);
    check("exp_add_ignored", count, 0);
    check("exp_stays", expired, 1);

    // Hold after two prescaler cycles, release, decrement 2 cycles later
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0, 0);
    check("hold_count", count, 60);
    check("hold_paused", paused, 1);
    step(0, 0, 0, 0, 0);
    check("resume_running", running, 1);
    idle(1);
    check("resume_pre", count, 60);
    idle(1);
    check("resume_dec", count, 59);
    check("resume_tick", tick, 1);

    // Saturating add
    step(0, 0, 0, 1, 36);
    check("add_95", count, 95);
    step(0, 0, 0, 1, 10);
    check("add_sat", count, 99);
    step(0, 1, 0, 0, 0);
    idle(40);
    check("at_50", count, 50);
    step(0, 0, 0, 1, 5);
    check("add_55", count, 55);

    // Add coinciding with the decrement that would have expired
    step(0, 1, 0, 0, 0);
    idle(236);
    check("at_1", count, 1);
    idle(3);
    step(0, 0, 0, 1, 3);
    check("rescue_count", count, 3);
    check("rescue_nopulse", expire_pulse, 0);
    idle(11);
    check("at_1_again", count, 1);
    idle(1);
    check("wrap_zero", count, 0);
    check("wrap_pulse", expire_pulse, 1);

    // Restart from EXPIRED, then reset mid-run
    step(0, 1, 0, 0, 0);
    check("restart_count", count, 60);
    check("restart_running", running, 1);
    idle(120);
    check("at_30", count, 30);
    step(1, 0, 0, 0, 0);
    check("midrst_count", count, 60);
    check("midrst_flags", {running, paused, expired, expire_pulse, tick}, 0);

    // Randomised phase
    r_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_hold = ~r_hold;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 59) == 0,
           r_hold,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 255));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_countdown_timer
